// File: rtl/aq_mmu_pkg.sv
// Shared types and constants for the uTLB miss arbiter slice.
// Holds FSM encodings, requester IDs and the lookup/result record layouts.
package aq_mmu_pkg;

   localparam int VPN_W  = 28;
   localparam int ASID_W = 16;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT  = 2'b01,
      ST_LOOKUP = 2'b10,
      ST_RESP   = 2'b11
   } arb_state_e;

   typedef struct packed {
      logic [VPN_W-1:0]  vpn;
      logic [ASID_W-1:0] asid;
      logic [1:0]        mode;
      logic              mach;
      logic              read;
   } lookup_t;

   typedef struct packed {
      logic pavld;
      logic pgflt;
      logic acc_err;
   } rsp_stat_t;

   localparam rsp_stat_t RSP_NONE = '{pavld: 1'b0, pgflt: 1'b0, acc_err: 1'b0};
   localparam rsp_stat_t RSP_TMO  = '{pavld: 1'b0, pgflt: 1'b0, acc_err: 1'b1};

   function automatic logic [1:0] src_onehot(input logic src);
      return src ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/aq_mmu_utlb_arb_if.sv
// Miss/refill bundle between the two uTLBs, the arbiter and the JTLB/PTW engine.
// slave = arbiter view, master = uTLB/JTLB environment view.
interface aq_mmu_utlb_arb_if;
   import aq_mmu_pkg::*;

   logic              iutlb_arb_req;
   logic              iutlb_arb_cmplt;
   logic [VPN_W-1:0]  iutlb_arb_vpn;
   logic [ASID_W-1:0] iutlb_arb_asid;
   logic [1:0]        iutlb_arb_mode;
   logic              iutlb_arb_mach;

   logic              dutlb_arb_req;
   logic              dutlb_arb_cmplt;
   logic [VPN_W-1:0]  dutlb_arb_vpn;
   logic [ASID_W-1:0] dutlb_arb_asid;
   logic [1:0]        dutlb_arb_mode;
   logic              dutlb_arb_mach;
   logic              dutlb_arb_read;

   logic              arb_iutlb_grant;
   logic              arb_dutlb_grant;

   logic              arb_jtlb_req;
   logic [VPN_W-1:0]  arb_jtlb_vpn;
   logic [ASID_W-1:0] arb_jtlb_asid;
   logic [1:0]        arb_jtlb_mode;
   logic              arb_jtlb_mach;
   logic              arb_jtlb_read;
   logic              arb_jtlb_src;

   logic              jtlb_arb_rsp_vld;
   logic              jtlb_arb_pavld;
   logic              jtlb_arb_pgflt;
   logic              jtlb_arb_acc_err;

   logic              jtlb_iutlb_ref_cmplt;
   logic              jtlb_iutlb_ref_pavld;
   logic              jtlb_iutlb_pgflt;
   logic              jtlb_iutlb_acc_err;

   logic              jtlb_dutlb_ref_cmplt;
   logic              jtlb_dutlb_ref_pavld;
   logic              jtlb_dutlb_pgflt;
   logic              jtlb_dutlb_acc_err;

   logic [1:0]        arb_top_cur_st;

   modport slave (
      input  iutlb_arb_req, iutlb_arb_cmplt, iutlb_arb_vpn, iutlb_arb_asid,
             iutlb_arb_mode, iutlb_arb_mach,
      input  dutlb_arb_req, dutlb_arb_cmplt, dutlb_arb_vpn, dutlb_arb_asid,
             dutlb_arb_mode, dutlb_arb_mach, dutlb_arb_read,
      input  jtlb_arb_rsp_vld, jtlb_arb_pavld, jtlb_arb_pgflt, jtlb_arb_acc_err,
      output arb_iutlb_grant, arb_dutlb_grant,
      output arb_jtlb_req, arb_jtlb_vpn, arb_jtlb_asid, arb_jtlb_mode,
             arb_jtlb_mach, arb_jtlb_read, arb_jtlb_src,
      output jtlb_iutlb_ref_cmplt, jtlb_iutlb_ref_pavld, jtlb_iutlb_pgflt,
             jtlb_iutlb_acc_err,
      output jtlb_dutlb_ref_cmplt, jtlb_dutlb_ref_pavld, jtlb_dutlb_pgflt,
             jtlb_dutlb_acc_err,
      output arb_top_cur_st
   );

   modport master (
      output iutlb_arb_req, iutlb_arb_cmplt, iutlb_arb_vpn, iutlb_arb_asid,
             iutlb_arb_mode, iutlb_arb_mach,
      output dutlb_arb_req, dutlb_arb_cmplt, dutlb_arb_vpn, dutlb_arb_asid,
             dutlb_arb_mode, dutlb_arb_mach, dutlb_arb_read,
      output jtlb_arb_rsp_vld, jtlb_arb_pavld, jtlb_arb_pgflt, jtlb_arb_acc_err,
      input  arb_iutlb_grant, arb_dutlb_grant,
      input  arb_jtlb_req, arb_jtlb_vpn, arb_jtlb_asid, arb_jtlb_mode,
             arb_jtlb_mach, arb_jtlb_read, arb_jtlb_src,
      input  jtlb_iutlb_ref_cmplt, jtlb_iutlb_ref_pavld, jtlb_iutlb_pgflt,
             jtlb_iutlb_acc_err,
      input  jtlb_dutlb_ref_cmplt, jtlb_dutlb_ref_pavld, jtlb_dutlb_pgflt,
             jtlb_dutlb_acc_err,
      input  arb_top_cur_st
   );

endinterface

// File: rtl/aq_mmu_rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, on a tie the side
// not served last wins. The pointer only moves when upd_en is pulsed.
module aq_mmu_rr_arb2
   import aq_mmu_pkg::*;
(
   input  logic       clk,
   input  logic       cpurst_b,
   input  logic [1:0] req,
   input  logic       upd_en,
   input  logic       upd_src,
   output logic [1:0] gnt
);

   logic       last_reg;
   logic       last_next;
   logic [1:0] fav_oh;

   always_comb begin
      last_next = last_reg;
      if (upd_en) begin
         last_next = upd_src;
      end
   end

   // Last-served starts at I so the first tie goes to D.
   always_ff @(posedge clk) begin
      if (!cpurst_b) begin
         last_reg <= SRC_I;
      end else begin
         last_reg <= last_next;
      end
   end

   assign fav_oh = src_onehot(~last_reg);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_gnt
         assign gnt[gi] = req[gi] & (~req[1-gi] | fav_oh[gi]);
      end
   endgenerate

endmodule

// File: rtl/aq_mmu_utlb_arb.sv
// Arbitrates I/D uTLB misses onto the JTLB/PTW engine and steers the result
// back to the owning uTLB; a watchdog turns a hung lookup into acc_err.
module aq_mmu_utlb_arb
   import aq_mmu_pkg::*;
#(
   parameter int unsigned       TMO_W   = 8,
   parameter logic [TMO_W-1:0]  TMO_MAX = 8'd200
)(
   input logic               mmu_top_clk,
   input logic               cpurst_b,
   aq_mmu_utlb_arb_if.slave  bus
);

   arb_state_e        st_reg, st_next;
   logic              owner_reg, owner_next;
   logic [1:0]        grant_reg, grant_next;
   lookup_t           lkp_reg, lkp_next;
   rsp_stat_t         stat_reg, stat_next;
   logic              cmplt_reg, cmplt_next;
   logic              abandon_reg, abandon_next;
   logic [TMO_W-1:0]  wdog_reg, wdog_next;

   logic [1:0]        req_vec;
   logic [1:0]        rr_gnt;
   logic              rr_upd;
   logic              sel_src;
   logic              owner_req;
   logic              owner_cmplt;
   logic              wdog_tmo;
   logic [TMO_W-1:0]  wdog_inc;
   logic              jtlb_req;
   lookup_t           i_lkp, d_lkp;
   logic [1:0]        owner_oh;
   logic [1:0]        side_cmplt, side_pavld, side_pgflt, side_acc_err;

   assign req_vec     = {bus.dutlb_arb_req, bus.iutlb_arb_req};
   assign sel_src     = rr_gnt[SRC_D];
   assign owner_req   = owner_reg ? bus.dutlb_arb_req   : bus.iutlb_arb_req;
   assign owner_cmplt = owner_reg ? bus.dutlb_arb_cmplt : bus.iutlb_arb_cmplt;

   // Instruction fetch misses are always looked up as reads.
   assign i_lkp = '{vpn: bus.iutlb_arb_vpn, asid: bus.iutlb_arb_asid,
                    mode: bus.iutlb_arb_mode, mach: bus.iutlb_arb_mach,
                    read: 1'b1};
   assign d_lkp = '{vpn: bus.dutlb_arb_vpn, asid: bus.dutlb_arb_asid,
                    mode: bus.dutlb_arb_mode, mach: bus.dutlb_arb_mach,
                    read: bus.dutlb_arb_read};

   // Fires on the cycle the counter would reach TMO_MAX; the counter never wraps.
   assign wdog_tmo = (wdog_reg >= TMO_MAX - 1'b1);
   assign wdog_inc = (wdog_reg >= TMO_MAX) ? wdog_reg : wdog_reg + 1'b1;

   aq_mmu_rr_arb2 u_rr (
      .clk      (mmu_top_clk),
      .cpurst_b (cpurst_b),
      .req      (req_vec),
      .upd_en   (rr_upd),
      .upd_src  (owner_reg),
      .gnt      (rr_gnt)
   );

   always_comb begin
      st_next      = st_reg;
      owner_next   = owner_reg;
      grant_next   = grant_reg;
      lkp_next     = lkp_reg;
      stat_next    = stat_reg;
      cmplt_next   = 1'b0;
      abandon_next = abandon_reg;
      wdog_next    = wdog_reg;
      rr_upd       = 1'b0;
      jtlb_req     = 1'b0;

      case (st_reg)
         ST_IDLE: begin
            if (|req_vec) begin
               st_next    = ST_GRANT;
               owner_next = sel_src;
               grant_next = rr_gnt;
               lkp_next   = sel_src ? d_lkp : i_lkp;
            end
         end
         ST_GRANT: begin
            wdog_next    = '0;
            abandon_next = 1'b0;
            if (owner_req) begin
               jtlb_req = 1'b1;
               st_next  = ST_LOOKUP;
            end else begin
               st_next    = ST_IDLE;
               grant_next = '0;
               rr_upd     = 1'b1;
            end
         end
         ST_LOOKUP: begin
            wdog_next = wdog_inc;
            if (!owner_req) begin
               abandon_next = 1'b1;
            end
            // An abandoned lookup still has to drain before the engine is reused.
            if (bus.jtlb_arb_rsp_vld || wdog_tmo) begin
               if (abandon_reg || !owner_req) begin
                  st_next      = ST_IDLE;
                  grant_next   = '0;
                  abandon_next = 1'b0;
                  rr_upd       = 1'b1;
               end else begin
                  st_next    = ST_RESP;
                  cmplt_next = 1'b1;
                  if (bus.jtlb_arb_rsp_vld) begin
                     stat_next = '{pavld: bus.jtlb_arb_pavld,
                                   pgflt: bus.jtlb_arb_pgflt,
                                   acc_err: bus.jtlb_arb_acc_err};
                  end else begin
                     stat_next = RSP_TMO;
                  end
               end
            end
         end
         ST_RESP: begin
            if (owner_cmplt || !owner_req) begin
               st_next    = ST_IDLE;
               grant_next = '0;
               stat_next  = RSP_NONE;
               rr_upd     = 1'b1;
            end
         end
         default: begin
            st_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge mmu_top_clk) begin
      if (!cpurst_b) begin
         st_reg      <= ST_IDLE;
         owner_reg   <= SRC_I;
         grant_reg   <= '0;
         lkp_reg     <= '0;
         stat_reg    <= RSP_NONE;
         cmplt_reg   <= 1'b0;
         abandon_reg <= 1'b0;
         wdog_reg    <= '0;
      end else begin
         st_reg      <= st_next;
         owner_reg   <= owner_next;
         grant_reg   <= grant_next;
         lkp_reg     <= lkp_next;
         stat_reg    <= stat_next;
         cmplt_reg   <= cmplt_next;
         abandon_reg <= abandon_next;
         wdog_reg    <= wdog_next;
      end
   end

   assign owner_oh = src_onehot(owner_reg);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_side
         assign side_cmplt[gi]   = cmplt_reg        & owner_oh[gi];
         assign side_pavld[gi]   = stat_reg.pavld   & owner_oh[gi];
         assign side_pgflt[gi]   = stat_reg.pgflt   & owner_oh[gi];
         assign side_acc_err[gi] = stat_reg.acc_err & owner_oh[gi];
      end
   endgenerate

   assign bus.arb_iutlb_grant      = grant_reg[SRC_I];
   assign bus.arb_dutlb_grant      = grant_reg[SRC_D];

   assign bus.arb_jtlb_req         = jtlb_req;
   assign bus.arb_jtlb_vpn         = lkp_reg.vpn;
   assign bus.arb_jtlb_asid        = lkp_reg.asid;
   assign bus.arb_jtlb_mode        = lkp_reg.mode;
   assign bus.arb_jtlb_mach        = lkp_reg.mach;
   assign bus.arb_jtlb_read        = lkp_reg.read;
   assign bus.arb_jtlb_src         = owner_reg;

   assign bus.jtlb_iutlb_ref_cmplt = side_cmplt[SRC_I];
   assign bus.jtlb_iutlb_ref_pavld = side_pavld[SRC_I];
   assign bus.jtlb_iutlb_pgflt     = side_pgflt[SRC_I];
   assign bus.jtlb_iutlb_acc_err   = side_acc_err[SRC_I];

   assign bus.jtlb_dutlb_ref_cmplt = side_cmplt[SRC_D];
   assign bus.jtlb_dutlb_ref_pavld = side_pavld[SRC_D];
   assign bus.jtlb_dutlb_pgflt     = side_pgflt[SRC_D];
   assign bus.jtlb_dutlb_acc_err   = side_acc_err[SRC_D];

   assign bus.arb_top_cur_st       = st_reg;

endmodule

// File: tb/tb_aq_mmu_utlb_arb.sv
// Directed bench for the uTLB miss arbiter: single miss, alternation, page
// fault, watchdog timeout, abandoned lookup and reset during a lookup.
module tb_aq_mmu_utlb_arb;

   logic clk = 1'b0;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;
   int   i_evt  = 0;
   int   d_evt  = 0;
   int   n;
   int   snap;

   aq_mmu_utlb_arb_if bus ();

   aq_mmu_utlb_arb #(
      .TMO_W   (8),
      .TMO_MAX (8'd200)
   ) dut (
      .mmu_top_clk (clk),
      .cpurst_b    (rst_b),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] i_outs();
      return {bus.arb_iutlb_grant, bus.jtlb_iutlb_ref_cmplt, bus.jtlb_iutlb_ref_pavld,
              bus.jtlb_iutlb_pgflt, bus.jtlb_iutlb_acc_err};
   endfunction

   function automatic logic [4:0] d_outs();
      return {bus.arb_dutlb_grant, bus.jtlb_dutlb_ref_cmplt, bus.jtlb_dutlb_ref_pavld,
              bus.jtlb_dutlb_pgflt, bus.jtlb_dutlb_acc_err};
   endfunction

   // Counts cycles on which any I-side / D-side output is active.
   always @(negedge clk) begin
      if (i_outs() != 5'b0) i_evt <= i_evt + 1;
      if (d_outs() != 5'b0) d_evt <= d_evt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iutlb_arb_req    = 1'b0;  bus.iutlb_arb_cmplt = 1'b0;
      bus.iutlb_arb_vpn    = '0;    bus.iutlb_arb_asid  = '0;
      bus.iutlb_arb_mode   = '0;    bus.iutlb_arb_mach  = 1'b0;
      bus.dutlb_arb_req    = 1'b0;  bus.dutlb_arb_cmplt = 1'b0;
      bus.dutlb_arb_vpn    = '0;    bus.dutlb_arb_asid  = '0;
      bus.dutlb_arb_mode   = '0;    bus.dutlb_arb_mach  = 1'b0;
      bus.dutlb_arb_read   = 1'b0;
      bus.jtlb_arb_rsp_vld = 1'b0;  bus.jtlb_arb_pavld  = 1'b0;
      bus.jtlb_arb_pgflt   = 1'b0;  bus.jtlb_arb_acc_err = 1'b0;
   endtask

   task automatic rsp(input logic vld, input logic pav, input logic pgf, input logic acc);
      bus.jtlb_arb_rsp_vld = vld;
      bus.jtlb_arb_pavld   = pav;
      bus.jtlb_arb_pgflt   = pgf;
      bus.jtlb_arb_acc_err = acc;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      rst_b = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got 0x0 exp 0x1");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst_b = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      $display("txn0 reset state");
      chk("rst_st",   32'(bus.arb_top_cur_st), 32'd0);
      chk("rst_i",    32'(i_outs()), 32'd0);
      chk("rst_d",    32'(d_outs()), 32'd0);
      chk("rst_jtlb", 32'({bus.arb_jtlb_req, bus.arb_jtlb_read, bus.arb_jtlb_src,
                           bus.arb_jtlb_mach, bus.arb_jtlb_mode}), 32'd0);
      chk("rst_vpn",  32'(bus.arb_jtlb_vpn), 32'd0);
      rst_b = 1'b1;

      // Single I miss, response three cycles after the launch.
      $display("txn1 single I miss vpn 0x0abcdef");
      bus.iutlb_arb_req = 1'b1;   bus.iutlb_arb_vpn  = 28'h0ABCDEF;
      bus.iutlb_arb_asid = 16'h1234; bus.iutlb_arb_mode = 2'b11; bus.iutlb_arb_mach = 1'b1;
      cyc();
      chk("t1_st_grant", 32'(bus.arb_top_cur_st), 32'd1);
      chk("t1_i_grant",  32'(i_outs()), 32'(5'b10000));
      chk("t1_d_quiet",  32'(d_outs()), 32'd0);
      chk("t1_jreq",     32'(bus.arb_jtlb_req), 32'd1);
      chk("t1_vpn_rd_src", 32'({bus.arb_jtlb_vpn, bus.arb_jtlb_read, bus.arb_jtlb_src}),
                           32'({28'h0ABCDEF, 1'b1, 1'b0}));
      chk("t1_asid_mode", 32'({bus.arb_jtlb_asid, bus.arb_jtlb_mode, bus.arb_jtlb_mach}),
                          32'({16'h1234, 2'b11, 1'b1}));
      cyc();
      chk("t1_jreq_pulse", 32'(bus.arb_jtlb_req), 32'd0);
      chk("t1_st_lookup",  32'(bus.arb_top_cur_st), 32'd2);
      cyc();
      cyc();
      chk("t1_wait", 32'(i_outs()), 32'(5'b10000));
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("t1_st_resp", 32'(bus.arb_top_cur_st), 32'd3);
      chk("t1_cmplt",   32'(i_outs()), 32'(5'b11100));
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("t1_hold1", 32'(i_outs()), 32'(5'b10100));
      cyc();
      chk("t1_hold2", 32'(i_outs()), 32'(5'b10100));
      bus.iutlb_arb_cmplt = 1'b1; bus.iutlb_arb_req = 1'b0;
      cyc();
      bus.iutlb_arb_cmplt = 1'b0;
      chk("t1_release", 32'({bus.arb_top_cur_st, i_outs()}), 32'd0);

      // Simultaneous requests from reset: D, then I, then D again.
      do_reset();
      $display("txn2 simultaneous I/D requests");
      bus.iutlb_arb_req = 1'b1; bus.iutlb_arb_vpn = 28'h1111111;
      bus.dutlb_arb_req = 1'b1; bus.dutlb_arb_vpn = 28'h2222222; bus.dutlb_arb_read = 1'b1;
      cyc();
      chk("t2_d_first", 32'({i_outs(), d_outs()}), 32'({5'b00000, 5'b10000}));
      chk("t2_d_attr",  32'({bus.arb_jtlb_vpn, bus.arb_jtlb_src}), 32'({28'h2222222, 1'b1}));
      cyc();
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_d_cmplt", 32'({i_outs(), d_outs()}), 32'({5'b00000, 5'b11100}));
      bus.dutlb_arb_cmplt = 1'b1; bus.dutlb_arb_req = 1'b0;
      cyc();
      bus.dutlb_arb_cmplt = 1'b0;
      chk("t2_gap", 32'({bus.arb_top_cur_st, i_outs(), d_outs()}), 32'd0);
      cyc();
      chk("t2_i_second", 32'({i_outs(), d_outs()}), 32'({5'b10000, 5'b00000}));
      chk("t2_i_attr",   32'({bus.arb_jtlb_vpn, bus.arb_jtlb_src}), 32'({28'h1111111, 1'b0}));
      cyc();
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_i_cmplt", 32'(i_outs()), 32'(5'b11100));
      bus.iutlb_arb_cmplt = 1'b1; bus.iutlb_arb_req = 1'b0;
      cyc();
      bus.iutlb_arb_cmplt = 1'b0;
      bus.iutlb_arb_req = 1'b1; bus.dutlb_arb_req = 1'b1;
      cyc();
      chk("t2_alt_d", 32'({i_outs(), d_outs()}), 32'({5'b00000, 5'b10000}));

      // D store page fault; I side must stay quiet throughout.
      do_reset();
      $display("txn3 D store page fault vpn 0x3c0ffee");
      snap = i_evt;
      bus.dutlb_arb_req = 1'b1; bus.dutlb_arb_vpn = 28'h3C0FFEE; bus.dutlb_arb_read = 1'b0;
      cyc();
      chk("t3_rd_src", 32'({bus.arb_jtlb_read, bus.arb_jtlb_src, d_outs()}),
                       32'({1'b0, 1'b1, 5'b10000}));
      cyc();
      rsp(1'b1, 1'b0, 1'b1, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_pgflt", 32'(d_outs()), 32'(5'b11010));
      bus.dutlb_arb_cmplt = 1'b1; bus.dutlb_arb_req = 1'b0;
      cyc();
      bus.dutlb_arb_cmplt = 1'b0;
      chk("t3_release", 32'(d_outs()), 32'd0);
      cyc();
      chk("t3_i_quiet", 32'(i_evt - snap), 32'd0);

      // Watchdog: no response, forced acc_err 200 cycles into LOOKUP.
      $display("txn4 lookup timeout");
      bus.iutlb_arb_req = 1'b1; bus.iutlb_arb_vpn = 28'h0000042;
      cyc();
      chk("t4_jreq", 32'(bus.arb_jtlb_req), 32'd1);
      cyc();
      n = 0;
      while (n < 300 && !bus.jtlb_iutlb_ref_cmplt) begin
         cyc();
         n++;
      end
      chk("t4_tmo_cycles", 32'(n), 32'd200);
      chk("t4_tmo_stat",   32'(i_outs()), 32'(5'b11001));
      bus.iutlb_arb_cmplt = 1'b1; bus.iutlb_arb_req = 1'b0;
      cyc();
      bus.iutlb_arb_cmplt = 1'b0;
      bus.iutlb_arb_req = 1'b1;
      cyc();
      cyc();
      for (int k = 0; k < 4; k++) cyc();
      chk("t4_wdog_clear", 32'({bus.arb_top_cur_st, i_outs()}), 32'({2'd2, 5'b10000}));
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_normal_rsp", 32'(i_outs()), 32'(5'b11100));

      // Abandon: D drops req mid-lookup, result is swallowed, I gets served.
      do_reset();
      $display("txn5 abandoned D lookup");
      bus.iutlb_arb_req = 1'b1; bus.iutlb_arb_vpn = 28'h0555555;
      bus.dutlb_arb_req = 1'b1; bus.dutlb_arb_vpn = 28'h0AAAAAA;
      cyc();
      chk("t5_d_owner", 32'(d_outs()), 32'(5'b10000));
      cyc();
      bus.dutlb_arb_req = 1'b0;
      cyc();
      chk("t5_still_lookup", 32'(bus.arb_top_cur_st), 32'd2);
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_discard", 32'({bus.arb_top_cur_st, i_outs(), d_outs()}), 32'd0);
      cyc();
      chk("t5_i_granted", 32'({i_outs(), bus.arb_jtlb_src, bus.arb_jtlb_vpn}),
                          32'({5'b10000, 1'b0, 28'h0555555}));

      // Reset asserted for one edge while I is in LOOKUP.
      $display("txn6 reset during lookup");
      cyc();
      chk("t6_pre", 32'(bus.arb_top_cur_st), 32'd2);
      rst_b = 1'b0;
      cyc();
      rst_b = 1'b1;
      bus.iutlb_arb_req = 1'b0;
      chk("t6_outs", 32'({bus.arb_top_cur_st, i_outs(), d_outs(), bus.arb_jtlb_req}), 32'd0);
      chk("t6_attr", 32'({bus.arb_jtlb_vpn, bus.arb_jtlb_src}), 32'd0);
      cyc();
      rsp(1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      rsp(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_late_rsp", 32'({bus.arb_top_cur_st, i_outs(), d_outs()}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aq_mmu_utlb_arb.md
Name: aq_mmu_utlb_arb

Overview:
- Arbiter and refill responder on the far side of the I-uTLB/D-uTLB miss interface.
- Accepts miss requests from both uTLBs, grants one at a time (round-robin), forwards the selected lookup to the JTLB/PTW engine, and steers the result back to the owning uTLB as per-requester completion and status strobes.
- Holds ownership until the owner signals cmplt; a watchdog converts a hung lookup into an access error.

Parameters:
- TMO_W, 8, width of lookup watchdog counter.
- TMO_MAX, 8'd200, cycles in LOOKUP before forced acc_err response.

Ports:
- mmu_top_clk  in  1  clock.
- cpurst_b  in  1  reset; synchronous, active-low.
- iutlb_arb_req / dutlb_arb_req  in  1  miss request, level, held until cmplt.
- iutlb_arb_cmplt / dutlb_arb_cmplt  in  1  owner releases grant (result consumed or request abandoned).
- iutlb_arb_vpn / dutlb_arb_vpn  in  28  miss VPN.
- iutlb_arb_asid / dutlb_arb_asid  in  16  ASID.
- iutlb_arb_mode / dutlb_arb_mode  in  2  privilege mode.
- iutlb_arb_mach / dutlb_arb_mach  in  1  machine-mode access.
- dutlb_arb_read  in  1  load (1) / store (0); the I side is forced read=1 internally.
- arb_iutlb_grant / arb_dutlb_grant  out  1  ownership, level.
- arb_jtlb_req  out  1  one-cycle lookup launch.
- arb_jtlb_vpn 28, arb_jtlb_asid 16, arb_jtlb_mode 2, arb_jtlb_mach 1, arb_jtlb_read 1, arb_jtlb_src 1 (0=I, 1=D)  out  latched lookup attributes.
- jtlb_arb_rsp_vld  in  1  lookup result strobe.
- jtlb_arb_pavld, jtlb_arb_pgflt, jtlb_arb_acc_err  in  1  result status.
- jtlb_iutlb_ref_cmplt, jtlb_iutlb_ref_pavld, jtlb_iutlb_pgflt, jtlb_iutlb_acc_err  out  1  I-side result.
- jtlb_dutlb_ref_cmplt, jtlb_dutlb_ref_pavld, jtlb_dutlb_pgflt, jtlb_dutlb_acc_err  out  1  D-side result.
- arb_top_cur_st  out  2  FSM state for debug/low-power handshake.

Behaviour:
- Reset (cpurst_b=0 at a clock edge):
  - all outputs 0; state IDLE; round-robin pointer favours D; watchdog 0.
  - Reset mid-operation drops grant and any pending result without emitting a response.
- FSM encoding: IDLE=00, GRANT=01, LOOKUP=10, RESP=11.
- IDLE:
  - If any req is set, select the owner: a single requester wins; if both request, the side not served last wins (pointer starts at D).
  - Next state GRANT; the owner's grant rises next cycle; lookup attributes are latched from the owner's inputs.
- GRANT:
  - arb_jtlb_req=1 for exactly this cycle; go to LOOKUP; clear watchdog.
  - If the owner's req is already 0, skip the launch and return to IDLE.
- LOOKUP:
  - Watchdog increments each cycle.
  - On jtlb_arb_rsp_vld: go to RESP.
    - Owner's ref_cmplt=1 for one cycle.
    - pavld, pgflt and acc_err are copied from the result and held until release.
  - If the watchdog reaches TMO_MAX first: go to RESP with acc_err=1, pavld=0, pgflt=0.
  - If the owner drops req during LOOKUP: wait for rsp_vld or timeout, discard the result (no strobes), then go to IDLE.
- RESP:
  - Grant held; status outputs held.
  - On owner cmplt=1 or owner req=0: clear grant and status, update the pointer to the owner, go to IDLE.
  - The next grant can be issued in the following IDLE cycle, so there is a minimum 1-cycle gap between owners.
- Invariants:
  - At most one grant is asserted at a time.
  - The non-owner's request stays pending, never dropped.
  - A cmplt from the non-owner is ignored.
  - Minimum miss-to-result latency is 3 cycles plus JTLB latency.
- rsp_vld outside LOOKUP is ignored.
- Watchdog saturates; it never wraps.

Decomposition:
- Shared package aq_mmu_pkg: state encodings, source ID constants (SRC_I=0, SRC_D=1), VPN/ASID width localparams (28/16).
- One natural sub-module: aq_mmu_rr_arb2, a 2-way round-robin selector with pointer register, update-enable and one-hot grant.
- Remaining FSM, request latch and watchdog live in the top.

Test Plan:
- Single I miss: iutlb_arb_req=1, vpn=0x0ABCDEF; rsp_vld with pavld=1 three cycles after arb_jtlb_req -> arb_iutlb_grant high, arb_jtlb_vpn=0x0ABCDEF, arb_jtlb_read=1, src=0; jtlb_iutlb_ref_cmplt one-cycle pulse; pavld held until iutlb_arb_cmplt.
- Simultaneous I and D requests from reset -> D granted first; after D cmplt, I granted two cycles later; a second simultaneous pair is then served D first again (alternation verified).
- D store page fault: dutlb_arb_read=0, response pgflt=1 -> arb_jtlb_read=0; jtlb_dutlb_pgflt=1 and pavld=0; no I-side output toggles.
- Timeout: no rsp_vld for TMO_MAX (200) cycles -> cmplt pulse with acc_err=1 at cycle 200; watchdog cleared on the next grant.
- Abandon: owner drops req during LOOKUP, then rsp_vld arrives -> no cmplt/status strobes, state returns to IDLE, pending other requester granted.
- Reset during LOOKUP: cpurst_b=0 for one edge -> all outputs 0 on the next cycle; a later rsp_vld is ignored.
